// File: rtl/batt_sched.sv
// Battery-conversion scheduler: shares the A2D between command battery reads and a periodic
// low-battery monitor. Define BATT_SCHED_TMO_EN to compile in the conversion timeout.
module batt_sched #(
  parameter int unsigned PERIOD_W   = 20,
  parameter logic [7:0]  LOW_THRESH = 8'hC0,
  parameter int unsigned LOW_CNT    = 4,
  parameter int unsigned TMO_W      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_strt_cnv,
  output logic        cmd_cnv_cmplt,
  output logic [7:0]  batt,
  output logic        a2d_strt_cnv,
  input  logic        a2d_cnv_cmplt,
  input  logic [11:0] res,
  output logic        low_batt,
  output logic        a2d_err,
  output logic        busy
);

  localparam logic [3:0] LowCntMax = 4'(LOW_CNT);

  typedef enum logic [1:0] {StIdle, StConvCmd, StConvMon} state_e;

  state_e              state_q, state_d;
  logic                pend_cmd_q, pend_cmd_d;
  logic                pend_mon_q, pend_mon_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [3:0]          low_cnt_q, low_cnt_d;
  logic                low_batt_q, low_batt_d;
  logic [7:0]          batt_q, batt_d;
  logic                cmd_cnv_cmplt_q, cmd_cnv_cmplt_d;
  logic                a2d_strt_cnv_q, a2d_strt_cnv_d;
  logic                busy_q, busy_d;
  logic                timer_wrap;
  logic                tmo_hit;
  logic                tmo_fire;
  logic [7:0]          sample;
  logic [3:0]          unused_res_lsb;

  assign sample         = res[11:4];
  assign unused_res_lsb = res[3:0];
  assign timer_wrap     = &timer_q;

`ifdef BATT_SCHED_TMO_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             a2d_err_q, a2d_err_d;

  assign tmo_hit = &tmo_q;
  assign a2d_err = a2d_err_q;

  // Holding the counter at zero in IDLE makes it start from zero on every conversion entry.
  always_comb begin
    tmo_d     = (state_q == StIdle) ? '0 : tmo_q + TMO_W'(1);
    a2d_err_d = a2d_err_q | tmo_fire;
  end
`else
  logic [TMO_W-1:0] unused_tmo_w;
  logic             unused_tmo_fire;

  assign unused_tmo_w    = '0;
  assign unused_tmo_fire = tmo_fire;
  assign tmo_hit         = 1'b0;
  assign a2d_err         = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    pend_cmd_d      = pend_cmd_q;
    pend_mon_d      = pend_mon_q | timer_wrap;
    timer_d         = timer_q + PERIOD_W'(1);
    low_cnt_d       = low_cnt_q;
    low_batt_d      = low_batt_q;
    batt_d          = batt_q;
    cmd_cnv_cmplt_d = 1'b0;
    a2d_strt_cnv_d  = 1'b0;
    tmo_fire        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Command wins over a pending monitor sample; stale completions are ignored here.
        if (pend_cmd_q || cmd_strt_cnv) begin
          state_d        = StConvCmd;
          pend_cmd_d     = 1'b0;
          a2d_strt_cnv_d = 1'b1;
        end else if (pend_mon_q) begin
          state_d        = StConvMon;
          pend_mon_d     = 1'b0;
          a2d_strt_cnv_d = 1'b1;
        end
      end
      StConvCmd: begin
        if (a2d_cnv_cmplt) begin
          batt_d          = sample;
          cmd_cnv_cmplt_d = 1'b1;
          state_d         = StIdle;
        end else if (tmo_hit) begin
          batt_d          = 8'h00;
          cmd_cnv_cmplt_d = 1'b1;
          tmo_fire        = 1'b1;
          state_d         = StIdle;
        end
      end
      StConvMon: begin
        if (cmd_strt_cnv) begin
          pend_cmd_d = 1'b1;
        end
        if (a2d_cnv_cmplt) begin
          if (sample < LOW_THRESH) begin
            if (low_cnt_q < LowCntMax) begin
              low_cnt_d = low_cnt_q + 4'd1;
            end
          end else begin
            low_cnt_d = 4'd0;
          end
          if (low_cnt_d == LowCntMax) begin
            low_batt_d = 1'b1;
          end
          state_d = StIdle;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      pend_cmd_q      <= 1'b0;
      pend_mon_q      <= 1'b0;
      timer_q         <= '0;
      low_cnt_q       <= 4'd0;
      low_batt_q      <= 1'b0;
      batt_q          <= 8'h00;
      cmd_cnv_cmplt_q <= 1'b0;
      a2d_strt_cnv_q  <= 1'b0;
      busy_q          <= 1'b0;
`ifdef BATT_SCHED_TMO_EN
      tmo_q           <= '0;
      a2d_err_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      pend_cmd_q      <= pend_cmd_d;
      pend_mon_q      <= pend_mon_d;
      timer_q         <= timer_d;
      low_cnt_q       <= low_cnt_d;
      low_batt_q      <= low_batt_d;
      batt_q          <= batt_d;
      cmd_cnv_cmplt_q <= cmd_cnv_cmplt_d;
      a2d_strt_cnv_q  <= a2d_strt_cnv_d;
      busy_q          <= busy_d;
`ifdef BATT_SCHED_TMO_EN
      tmo_q           <= tmo_d;
      a2d_err_q       <= a2d_err_d;
`endif
    end
  end

  assign cmd_cnv_cmplt = cmd_cnv_cmplt_q;
  assign batt          = batt_q;
  assign a2d_strt_cnv  = a2d_strt_cnv_q;
  assign low_batt      = low_batt_q;
  assign busy          = busy_q;

endmodule

// File: doc/batt_sched.md
# batt_sched

Battery-conversion scheduler between the command configuration FSM and the A2D interface. It shares the single A2D conversion resource between two requesters: on-demand battery requests from the remote (REQ_BATT path) and a periodic low-battery monitor. It returns the 8-bit battery reading and completion pulse the command FSM expects, and raises a sticky `low_batt` flag for emergency-land logic.

## Interface
- `PERIOD_W`, default 20: monitor period timer width; a monitor request is raised every 2^PERIOD_W cycles.
- `LOW_THRESH`, default 8'hC0: a monitor sample with `res[11:4] < LOW_THRESH` counts as low.
- `LOW_CNT`, default 4: number of consecutive low monitor samples that sets `low_batt` (1..15).
- `TMO_W`, default 12: conversion timeout counter width (used only when the timeout feature is compiled in).
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `cmd_strt_cnv`, input, 1: one-cycle battery request from the command FSM.
- `cmd_cnv_cmplt`, output, 1: one-cycle pulse; `batt` is valid in the same cycle.
- `batt`, output, 8: last command-conversion result, `res[11:4]`.
- `a2d_strt_cnv`, output, 1: one-cycle start pulse to the A2D interface.
- `a2d_cnv_cmplt`, input, 1: conversion-complete pulse from the A2D interface.
- `res`, input, 12: A2D result, valid while `a2d_cnv_cmplt` is high.
- `low_batt`, output, 1: sticky low-battery flag.
- `a2d_err`, output, 1: sticky A2D timeout flag.
- `busy`, output, 1: high in any conversion state.

## Operation
- FSM states: IDLE, CONV_CMD, CONV_MON.
- Pending flags `pend_cmd` and `pend_mon`, one deep each:
  - `pend_cmd` is set by `cmd_strt_cnv`.
  - `pend_mon` is set when the period timer wraps (all ones to 0).
  - Extra requests while a flag is already set are dropped.
- IDLE:
  - If `pend_cmd` or `cmd_strt_cnv` is high, go to CONV_CMD. The command request has priority.
  - Else if `pend_mon` is high, go to CONV_MON.
  - The flag being serviced clears on entry to its conversion state.
- CONV_CMD: on `a2d_cnv_cmplt`, register `batt <= res[11:4]`, pulse `cmd_cnv_cmplt`, and return to IDLE.
- CONV_MON: on `a2d_cnv_cmplt`:
  - If `res[11:4] < LOW_THRESH`, increment the low counter, saturating at LOW_CNT.
  - Otherwise clear the counter.
  - Set `low_batt` when the counter reaches LOW_CNT.
  - Return to IDLE.
  - `batt` and `cmd_cnv_cmplt` are not touched.
- `cmd_strt_cnv` during CONV_MON sets `pend_cmd`. It is serviced after the monitor conversion with a fresh conversion; the monitor result is not reused.
- `cmd_strt_cnv` during CONV_CMD is ignored, because the command FSM never overlaps requests.
- `a2d_cnv_cmplt` in IDLE is ignored. This covers a stale completion after a reset.
- The period timer free-runs in all states.
- `low_batt` and `a2d_err` clear only on reset.

## Timing
- Reset values:
  - State is IDLE.
  - All pending flags, the timer, the low counter and the timeout counter are 0.
  - `batt` = 8'h00.
  - `cmd_cnv_cmplt`, `a2d_strt_cnv`, `low_batt`, `a2d_err` and `busy` are 0.
- All outputs are registered.
- `a2d_strt_cnv` is high for exactly one cycle: the first cycle in CONV_CMD or CONV_MON.
- Command latency from an idle block:
  - `cmd_strt_cnv` in cycle N.
  - `a2d_strt_cnv` in cycle N+1.
  - `cmd_cnv_cmplt` one cycle after `a2d_cnv_cmplt`.
  - `busy` drops in the same cycle as `cmd_cnv_cmplt`.
- Simultaneous `cmd_strt_cnv` and timer wrap in IDLE: the command conversion runs first, `pend_mon` is set, and CONV_MON starts one IDLE cycle after the command completes.
- Reset mid-conversion aborts the conversion immediately. No `cmd_cnv_cmplt` is issued.
- Wrap-around: the period timer wraps naturally. The low counter saturates and never wraps.

## Configuration
- `BATT_SCHED_TMO_EN` defined (timeout feature compiled in):
  - A TMO_W-bit counter clears on entry to each conversion state and increments each cycle in it.
  - At all ones without completion, set `a2d_err` and return to IDLE.
  - If the state was CONV_CMD, also set `batt <= 8'h00` and pulse `cmd_cnv_cmplt`, so the command FSM never hangs.
  - If the state was CONV_MON, the low counter is unchanged.
- `BATT_SCHED_TMO_EN` undefined: no timeout counter. Conversion states wait indefinitely and `a2d_err` is tied to 0.

## Test plan
- Idle command path: pulse `cmd_strt_cnv`, then return `res`=12'hAB3 four cycles after `a2d_strt_cnv` -> `a2d_strt_cnv` is a single pulse one cycle after the request; `batt`=8'hAB with a single `cmd_cnv_cmplt` one cycle after completion.
- Collision: `cmd_strt_cnv` in the same cycle as the timer wrap -> CONV_CMD runs first, then exactly one monitor `a2d_strt_cnv`; `batt` reflects only the command result.
- Command during monitor: request during CONV_MON -> the monitor completes, then a second `a2d_strt_cnv` is issued and `cmd_cnv_cmplt` follows the second completion only.
- Low battery with LOW_CNT=4 and LOW_THRESH=8'hC0: monitor samples 8'hBF,8'hBF,8'hC0,8'hBF×4 -> `low_batt` stays 0 until the 4th consecutive low sample, then stays 1 through subsequent high samples.
- Timeout (BATT_SCHED_TMO_EN, TMO_W=4): command request with no completion -> `a2d_err`=1 and `cmd_cnv_cmplt` with `batt`=8'h00 after 15 cycles in CONV_CMD; without the macro the block stays busy indefinitely.
- Reset mid-CONV_CMD, then a stale `a2d_cnv_cmplt` -> no `cmd_cnv_cmplt`, `batt`=8'h00, state IDLE.
